redmule_mem_port_arbiter: RTL



---
 rtl/redmule_mem_port_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/redmule_mem_port_arbiter.sv
// Burst-locking arbiter sharing RedMulE's single memory port among the streamer channels.
// Define REDMULE_ARB_STATS_EN to build the per-channel completed-burst counters.
module redmule_mem_port_arbiter #(
    parameter int unsigned NumReq     = 6,
    parameter int unsigned ZIdx       = 3,
    parameter int unsigned MaxZBursts = 4,
    parameter int unsigned CntW       = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      z_priority_i,
    input  logic [NumReq-1:0]         req_i,
    input  logic [NumReq-1:0]         last_i,
    input  logic                      mem_gnt_i,
    output logic                      mem_req_o,
    output logic [$clog2(NumReq)-1:0] sel_o,
    output logic [NumReq-1:0]         gnt_o,
    output logic                      busy_o,
    output logic [NumReq*CntW-1:0]    stat_cnt_o
);

    localparam int unsigned SelW = $clog2(NumReq);
    localparam int unsigned StrW = $clog2(MaxZBursts + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state;
    logic [SelW-1:0]   sel_q;
    logic [SelW-1:0]   rr_ptr;
    logic [StrW-1:0]   z_streak;

    logic              beat_acc;
    logic              burst_done;
    logic              arb_now;
    logic              z_win;
    logic              rr_found;
    logic [SelW-1:0]   rr_win;
    logic [NumReq-1:0] rr_cand;

    assign mem_req_o  = (state == LOCKED) & req_i[sel_q];
    assign beat_acc   = mem_req_o & mem_gnt_i;
    assign burst_done = beat_acc & last_i[sel_q];
    assign arb_now    = (state == IDLE) | burst_done;
    assign busy_o     = (state == LOCKED);
    assign sel_o      = sel_q;

    always_comb begin
        gnt_o        = '0;
        gnt_o[sel_q] = beat_acc;
    end

    // The finishing channel's request covers its own last beat, so it may not re-win
    // through round-robin; a prioritised Z that stays high is taken as chaining its next burst.
    always_comb begin
        rr_cand = req_i;
        if (state == LOCKED) rr_cand[sel_q] = 1'b0;
    end

    assign z_win = z_priority_i & req_i[ZIdx] & (z_streak < StrW'(MaxZBursts));

    // Descending scan so the candidate closest to rr_ptr is the one left standing.
    always_comb begin
        logic [SelW:0] pos;
        rr_found = 1'b0;
        rr_win   = '0;
        pos      = '0;
        for (int k = int'(NumReq) - 1; k >= 0; k--) begin
            pos = {1'b0, rr_ptr} + (SelW+1)'(k);
            if (pos >= (SelW+1)'(NumReq)) pos = pos - (SelW+1)'(NumReq);
            if (rr_cand[pos[SelW-1:0]]) begin
                rr_found = 1'b1;
                rr_win   = pos[SelW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state    <= IDLE;
            sel_q    <= '0;
            rr_ptr   <= '0;
            z_streak <= '0;
        end else if (arb_now) begin
            if (z_win) begin
                state    <= LOCKED;
                sel_q    <= SelW'(ZIdx);
                z_streak <= z_streak + 1'b1;
            end else if (rr_found) begin
                state    <= LOCKED;
                sel_q    <= rr_win;
                rr_ptr   <= (rr_win == SelW'(NumReq - 1)) ? '0 : rr_win + 1'b1;
                z_streak <= '0;
            end else begin
                state    <= IDLE;
            end
        end
    end

`ifdef REDMULE_ARB_STATS_EN
    logic [CntW-1:0] stat_q [NumReq];

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int c = 0; c < int'(NumReq); c++) stat_q[c] <= '0;
        end else if (burst_done && (stat_q[sel_q] != '1)) begin
            stat_q[sel_q] <= stat_q[sel_q] + 1'b1;
        end
    end

    for (genvar g = 0; g < int'(NumReq); g++) begin : g_stat
        assign stat_cnt_o[g*CntW +: CntW] = stat_q[g];
    end
`else
    assign stat_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    // A locked channel must keep requesting until its last beat is accepted.
    always_ff @(posedge clk_i) begin
        assert (rst_i || clear_i || (state != LOCKED) || req_i[sel_q])
            else $error("request dropped mid-burst by channel %0d", sel_q);
    end
`endif

endmodule
